pipe_rx_lane_packer: RTL and testbench

- Parametrised successor to the PHY RX lane packer. Sits between the PIPE RX interface and the RX elastic FIFO.
- Per lane, it accumulates narrow PIPE beats of 1, 2 or 4 bytes into DATA_WIDTH-bit words, in lockstep across the active lanes.
- Adds what the earlier packer lacked: an output valid/ready handshake, overflow detection, lane reversal, flush on link-down or width change, and error flags.

---
 rtl/pipe_rx_lane_packer.sv | 178 +++++++++++++++++
 tb/tb_pipe_rx_lane_packer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_rx_lane_packer.sv
// PIPE RX lane packer: gathers 1/2/4-byte PIPE beats per lane into DATA_WIDTH-bit words,
// in lockstep across the active lanes, behind a valid/ready output register.
module pipe_rx_lane_packer #(
    parameter int DATA_WIDTH    = 32,
    parameter int MAX_NUM_LANES = 16
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic                                    phy_link_up_i,
    input  logic                                    lane_reverse_i,
    input  logic [5:0]                              pipe_width_i,
    input  logic [5:0]                              num_active_lanes_i,
    input  logic [MAX_NUM_LANES*DATA_WIDTH-1:0]     data_i,
    input  logic [MAX_NUM_LANES-1:0]                data_valid_i,
    input  logic [MAX_NUM_LANES*(DATA_WIDTH/8)-1:0] data_k_i,
    input  logic [2*MAX_NUM_LANES-1:0]              sync_header_i,
    output logic [MAX_NUM_LANES*DATA_WIDTH-1:0]     data_o,
    output logic [MAX_NUM_LANES-1:0]                data_valid_o,
    output logic [MAX_NUM_LANES*(DATA_WIDTH/8)-1:0] data_k_o,
    output logic [2*MAX_NUM_LANES-1:0]              sync_header_o,
    input  logic                                    out_ready_i,
    output logic                                    fifo_wr_o,
    output logic                                    overflow_o,
    output logic                                    err_o
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int CW    = $clog2(BYTES) + 1;

    typedef enum logic {ST_IDLE, ST_FILL} state_t;

    state_t                                   state_p0, state_nxt;
    logic [CW-1:0]                            cnt_p0, cnt_nxt;
    logic [5:0]                               width_p0;
    logic [5:0]                               lanes_p0, lanes_nxt;
    logic [MAX_NUM_LANES-1:0][DATA_WIDTH-1:0] acc_p0, acc_nxt, word_nxt;
    logic [MAX_NUM_LANES-1:0][BYTES-1:0]      acck_p0, acck_nxt, wordk_nxt;
    logic [MAX_NUM_LANES-1:0][1:0]            accsh_p0, accsh_nxt, wordsh_nxt;
    logic [MAX_NUM_LANES-1:0]                 wordv_nxt;
    logic                                     width_ok, complete, err_nxt;
    logic                                     held, accept, load;
    int                                       bpb, base, nl;

    always_comb begin
        state_nxt  = state_p0;
        cnt_nxt    = cnt_p0;
        lanes_nxt  = lanes_p0;
        acc_nxt    = acc_p0;
        acck_nxt   = acck_p0;
        accsh_nxt  = accsh_p0;
        word_nxt   = '0;
        wordk_nxt  = '0;
        wordsh_nxt = '0;
        wordv_nxt  = '0;
        complete   = 1'b0;
        err_nxt    = 1'b0;
        bpb        = int'(pipe_width_i) >> 3;
        width_ok   = (pipe_width_i == 6'd8 || pipe_width_i == 6'd16 || pipe_width_i == 6'd32)
                     && (int'(pipe_width_i) <= DATA_WIDTH);
        base       = int'(cnt_p0);

        // A width change strands the partial word at a misaligned offset, so restart it.
        if (pipe_width_i != width_p0 && cnt_p0 != '0) begin
            base      = 0;
            acc_nxt   = '0;
            acck_nxt  = '0;
            accsh_nxt = '0;
        end
        nl = int'((base == 0) ? num_active_lanes_i : lanes_p0);
        if (nl > MAX_NUM_LANES) nl = MAX_NUM_LANES;

        if (phy_link_up_i && !width_ok) err_nxt = 1'b1;

        case (state_p0)
            ST_IDLE: begin
                if (phy_link_up_i && width_ok) state_nxt = ST_FILL;
            end
            ST_FILL: begin
                if (!phy_link_up_i) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                    acc_nxt   = '0;
                    acck_nxt  = '0;
                    accsh_nxt = '0;
                end else if (!width_ok) begin
                    cnt_nxt = CW'(base);
                end else begin
                    for (int l = 0; l < MAX_NUM_LANES; l++)
                        if (l < nl && data_valid_i[l] != data_valid_i[0]) err_nxt = 1'b1;
                    cnt_nxt = CW'(base);
                    if (data_valid_i[0]) begin
                        if (base == 0) lanes_nxt = num_active_lanes_i;
                        for (int l = 0; l < MAX_NUM_LANES; l++) begin
                            if (l < nl) begin
                                for (int p = 0; p < BYTES; p++)
                                    for (int b = 0; b < 4; b++)
                                        if (b < bpb && p == base + b) begin
                                            acc_nxt[l][p*8 +: 8] = data_i[l*DATA_WIDTH + b*8 +: 8];
                                            acck_nxt[l][p]       = data_k_i[l*BYTES + b];
                                        end
                                if (base == 0) accsh_nxt[l] = sync_header_i[2*l +: 2];
                            end else begin
                                acc_nxt[l]   = '0;
                                acck_nxt[l]  = '0;
                                accsh_nxt[l] = '0;
                            end
                        end
                        if (base + bpb >= BYTES) begin
                            complete = 1'b1;
                            cnt_nxt  = '0;
                        end else begin
                            cnt_nxt = CW'(base + bpb);
                        end
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Reversal only permutes lanes; bytes inside a lane keep their order.
        if (complete) begin
            for (int i = 0; i < MAX_NUM_LANES; i++) begin
                wordv_nxt[i] = (i < nl);
                for (int j = 0; j < MAX_NUM_LANES; j++)
                    if (i < nl && j < nl && (lane_reverse_i ? (i + j == nl - 1) : (i == j))) begin
                        word_nxt[i]   = acc_nxt[j];
                        wordk_nxt[i]  = acck_nxt[j];
                        wordsh_nxt[i] = accsh_nxt[j];
                    end
            end
            acc_nxt   = '0;
            acck_nxt  = '0;
            accsh_nxt = '0;
        end
    end

    assign held      = |data_valid_o;
    assign accept    = held && out_ready_i;
    assign load      = complete && (!held || out_ready_i);
    assign fifo_wr_o = accept;

    // Stage p0: accumulators; output register follows the completed word.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_p0      <= ST_IDLE;
            cnt_p0        <= '0;
            width_p0      <= '0;
            lanes_p0      <= '0;
            acc_p0        <= '0;
            acck_p0       <= '0;
            accsh_p0      <= '0;
            data_o        <= '0;
            data_valid_o  <= '0;
            data_k_o      <= '0;
            sync_header_o <= '0;
            overflow_o    <= 1'b0;
            err_o         <= 1'b0;
        end else begin
            state_p0   <= state_nxt;
            cnt_p0     <= cnt_nxt;
            width_p0   <= pipe_width_i;
            lanes_p0   <= lanes_nxt;
            acc_p0     <= acc_nxt;
            acck_p0    <= acck_nxt;
            accsh_p0   <= accsh_nxt;
            overflow_o <= complete && held && !out_ready_i;
            err_o      <= err_nxt;
            if (load) begin
                data_o        <= word_nxt;
                data_valid_o  <= wordv_nxt;
                data_k_o      <= wordk_nxt;
                sync_header_o <= wordsh_nxt;
            end else if (accept) begin
                data_valid_o <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pipe_rx_lane_packer.sv
// Directed and randomized bench for pipe_rx_lane_packer (DATA_WIDTH=32, 16 lanes),
// randomized words compared against a byte-stream reference model.
module tb_pipe_rx_lane_packer;
    localparam int DW = 32;
    localparam int NL = 16;
    localparam int BY = DW / 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, link, rev, rdy;
    logic [5:0] pw, nla;
    logic [NL*DW-1:0] din, dout;
    logic [NL-1:0] vin, vout;
    logic [NL*BY-1:0] kin, kout;
    logic [2*NL-1:0] shin, shout;
    logic fwr, ovf, err;

    int n_pass = 0;
    int n_total = 0;

    pipe_rx_lane_packer #(.DATA_WIDTH(DW), .MAX_NUM_LANES(NL)) dut (
        .clk_i(clk), .rst_i(rst), .phy_link_up_i(link), .lane_reverse_i(rev),
        .pipe_width_i(pw), .num_active_lanes_i(nla), .data_i(din), .data_valid_i(vin),
        .data_k_i(kin), .sync_header_i(shin), .data_o(dout), .data_valid_o(vout),
        .data_k_o(kout), .sync_header_o(shout), .out_ready_i(rdy), .fifo_wr_o(fwr),
        .overflow_o(ovf), .err_o(err)
    );

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive the same beat value on every lane for one cycle.
    task automatic beat_all(input logic [31:0] val, input logic [3:0] k, input logic [1:0] sh);
        for (int l = 0; l < NL; l++) begin
            din[l*DW +: DW]  = val;
            kin[l*BY +: BY]  = k;
            shin[2*l +: 2]   = sh;
        end
        vin = '1;
        step();
        vin = '0;
    endtask

    function automatic logic [511:0] rep_word(input logic [31:0] w, input int n);
        logic [511:0] r;
        r = '0;
        for (int l = 0; l < n; l++) r[l*DW +: DW] = w;
        return r;
    endfunction

    logic [31:0] ew [NL];
    logic [3:0]  ek [NL];
    logic [1:0]  es [NL];
    logic [511:0] e_d;
    logic [63:0]  e_k;
    logic [31:0]  e_s;
    logic [15:0]  e_v;
    int n, bpb, src, p;

    initial begin
        rst = 1'b1; link = 1'b0; rev = 1'b0; rdy = 1'b0;
        pw = 6'd8; nla = 6'd4; din = '0; vin = '0; kin = '0; shin = '0;
        repeat (3) step();
        chk("rst_valid", vout, 0);
        chk("rst_data", dout, 0);
        chk("rst_k", kout, 0);
        chk("rst_sh", shout, 0);
        chk("rst_fwr", fwr, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;

        // x4, width 8, bytes 11..44
        link = 1'b1; rdy = 1'b1;
        step();
        for (int j = 0; j < 4; j++) beat_all(32'(8'h11 * (j + 1)), (j == 0) ? 4'h1 : 4'h0, 2'b00);
        chk("t1_valid", vout, 16'h000F);
        chk("t1_data", dout, rep_word(32'h44332211, 4));
        chk("t1_k", kout, 64'h1111);
        chk("t1_fwr", fwr, 1);
        step();
        chk("t1_clear", vout, 0);
        chk("t1_fwr_off", fwr, 0);

        // x2, width 16, consumer stalled -> overflow on second word
        pw = 6'd16; nla = 6'd2; rdy = 1'b0;
        for (int j = 0; j < 4; j++) begin
            beat_all(32'(16'hB1B0 + 16'h0202 * j), 4'h0, 2'b00);
            if (j == 1) begin
                chk("t2_valid1", vout, 16'h0003);
                chk("t2_word1", dout, rep_word(32'hB3B2B1B0, 2));
                chk("t2_ovf_none", ovf, 0);
            end
        end
        chk("t2_ovf", ovf, 1);
        chk("t2_held_valid", vout, 16'h0003);
        chk("t2_held_data", dout, rep_word(32'hB3B2B1B0, 2));
        step();
        chk("t2_ovf_pulse", ovf, 0);
        rdy = 1'b1;
        #1;
        chk("t2_fwr", fwr, 1);
        chk("t2_acc_data", dout, rep_word(32'hB3B2B1B0, 2));
        step();
        chk("t2_clear", vout, 0);

        // x4, width 32, lane reversal
        pw = 6'd32; nla = 6'd4; rev = 1'b1;
        for (int l = 0; l < NL; l++) begin
            din[l*DW +: DW] = 32'hA0 + 32'(l);
            kin[l*BY +: BY] = 4'(l);
        end
        vin = '1;
        step();
        vin = '0;
        e_d = '0;
        for (int i = 0; i < 4; i++) e_d[i*DW +: DW] = 32'hA3 - 32'(i);
        chk("t3_valid", vout, 16'h000F);
        chk("t3_data", dout, e_d);
        chk("t3_k", kout, 64'h0123);
        rev = 1'b0;
        step();
        chk("t3_clear", vout, 0);

        // link drop mid-word discards the partial bytes
        pw = 6'd8; nla = 6'd2;
        beat_all(32'hD1, 4'h0, 2'b00);
        beat_all(32'hD2, 4'h0, 2'b00);
        link = 1'b0;
        step();
        link = 1'b1;
        step();
        chk("t4_no_partial", vout, 0);
        for (int j = 0; j < 4; j++) beat_all(32'hC1 + 32'(j), 4'h0, 2'b00);
        chk("t4_valid", vout, 16'h0003);
        chk("t4_data", dout, rep_word(32'hC4C3C2C1, 2));
        step();

        // x1 sync header capture, then illegal width
        nla = 6'd1;
        for (int j = 0; j < 4; j++) beat_all(32'h5A, 4'h0, (j == 0) ? 2'b01 : 2'b10);
        chk("t5_valid", vout, 16'h0001);
        chk("t5_sh", shout, 32'h1);
        chk("t5_data", dout, rep_word(32'h5A5A5A5A, 1));
        pw = 6'd24; vin = '1;
        for (int j = 0; j < 4; j++) begin
            step();
            chk("t5_err", err, 1);
            chk("t5_no_out", vout, 0);
        end
        pw = 6'd8; vin = '0;
        step();
        chk("t5_err_off", err, 0);
        chk("t5_still_none", vout, 0);

        // lane skew: lane 0 valid, lane 1 not -> error, beat still taken
        pw = 6'd32; nla = 6'd2;
        for (int l = 0; l < NL; l++) din[l*DW +: DW] = 32'hE0 + 32'(l);
        vin = 16'h0001;
        step();
        vin = '0;
        chk("t6_err", err, 1);
        chk("t6_valid", vout, 16'h0003);
        e_d = '0;
        e_d[0 +: DW] = 32'hE0;
        e_d[DW +: DW] = 32'hE1;
        chk("t6_data", dout, e_d);
        step();
        chk("t6_err_off", err, 0);

        // randomized words against the byte-stream model
        for (int w = 0; w < 40; w++) begin
            case ($urandom_range(0, 2))
                0: bpb = 1;
                1: bpb = 2;
                default: bpb = 4;
            endcase
            n = int'($urandom_range(1, NL));
            pw = 6'(bpb * 8);
            nla = 6'(n);
            rev = 1'($urandom);
            for (int l = 0; l < NL; l++) begin
                ew[l] = '0; ek[l] = '0; es[l] = '0;
            end
            for (int j = 0; j < BY / bpb; j++) begin
                if (j > 0) nla = 6'($urandom_range(1, NL));
                if ($urandom_range(0, 3) == 0) begin
                    vin = '0;
                    step();
                end
                for (int l = 0; l < NL; l++) begin
                    din[l*DW +: DW] = $urandom;
                    kin[l*BY +: BY] = 4'($urandom);
                    shin[2*l +: 2]  = 2'($urandom);
                end
                for (int l = 0; l < n; l++) begin
                    for (int b = 0; b < bpb; b++) begin
                        p = j * bpb + b;
                        ew[l][p*8 +: 8] = din[l*DW + b*8 +: 8];
                        ek[l][p]        = kin[l*BY + b];
                    end
                    if (j == 0) es[l] = shin[2*l +: 2];
                end
                vin = '1;
                step();
            end
            vin = '0;
            e_d = '0; e_k = '0; e_s = '0; e_v = '0;
            for (int i = 0; i < n; i++) begin
                src = rev ? (n - 1 - i) : i;
                e_d[i*DW +: DW] = ew[src];
                e_k[i*BY +: BY] = ek[src];
                e_s[2*i +: 2]   = es[src];
                e_v[i]          = 1'b1;
            end
            chk("rnd_valid", vout, e_v);
            chk("rnd_data", dout, e_d);
            chk("rnd_k", kout, e_k);
            chk("rnd_sh", shout, e_s);
            chk("rnd_ovf", ovf, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
